// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Brief    : APB initiator turning single host read/write commands into
//            SETUP/ACCESS transfers; returns a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int READ_LATE       = 1,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_error,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PWRITE,
    output logic                       PSEL,
    output logic                       PENABLE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETUP   = 2'd1;
    localparam logic [1:0] c_ACCESS  = 2'd2;
    localparam logic [1:0] c_CAPTURE = 2'd3;

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [1:0]                 r_state;
    logic [c_CNT_W-1:0]         r_wait_cnt;

    logic [1:0]                 w_state_nxt;
    logic [c_CNT_W-1:0]         w_cnt_nxt;
    logic                       w_psel_nxt;
    logic                       w_penable_nxt;
    logic [AMBA_ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [AMBA_WORD-1:0]       w_pwdata_nxt;
    logic                       w_pwrite_nxt;
    logic                       w_rsp_valid_nxt;
    logic [AMBA_WORD-1:0]       w_rsp_rdata_nxt;
    logic                       w_rsp_error_nxt;
    logic                       w_accept;
    logic                       w_timeout;

    assign cmd_ready = (r_state == c_IDLE) & ~rst;
    assign w_accept  = cmd_valid & cmd_ready;
    // Timeout fires on the last permitted wait cycle, so the access phase
    // lasts exactly TIMEOUT_CYCLES cycles when the slave never responds.
    assign w_timeout = (TIMEOUT_CYCLES > 0) && !PREADY && (r_wait_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_paddr_nxt     = PADDR;
        w_pwdata_nxt    = PWDATA;
        w_pwrite_nxt    = PWRITE;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_rsp_error_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
                    w_pwrite_nxt = cmd_write;
                    w_psel_nxt   = 1'b1;
                    w_state_nxt  = c_SETUP;
                end
            end
            c_SETUP: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_state_nxt   = c_ACCESS;
            end
            c_ACCESS: begin
                if (PREADY) begin
                    if (PWRITE) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = c_IDLE;
                    end else if (READ_LATE == 0) begin
                        w_rsp_rdata_nxt = PRDATA;
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = c_IDLE;
                    end else begin
                        w_state_nxt = c_CAPTURE;
                    end
                end else if (w_timeout) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_state_nxt     = c_IDLE;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_cnt_nxt     = r_wait_cnt + 1'b1;
                end
            end
            c_CAPTURE: begin
                // Registered-PRDATA slave presents data the cycle after access.
                w_rsp_rdata_nxt = PRDATA;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            PSEL       <= w_psel_nxt;
            PENABLE    <= w_penable_nxt;
            PADDR      <= w_paddr_nxt;
            PWDATA     <= w_pwdata_nxt;
            PWRITE     <= w_pwrite_nxt;
            rsp_valid  <= w_rsp_valid_nxt;
            rsp_rdata  <= w_rsp_rdata_nxt;
            rsp_error  <= w_rsp_error_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Brief    : Self-checking bench for apb_cmd_master with a register-file slave
//            and a host-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem   [4];
    logic [DW-1:0] slave_mem [4];

    always #5 clk = ~clk;

    apb_cmd_master #(
        .AMBA_ADDR_WIDTH(AW),
        .AMBA_WORD      (DW),
        .READ_LATE      (1),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // response cycle so a following call lands in that same cycle.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int waits, input bit hold);
        int            n_acc;
        int            rsp_cyc;
        bit            to;
        bit            late;
        bit            exp_psel;
        bit            exp_pen;
        logic [DW-1:0] exp_rd;
        to      = (waits >= TO);
        n_acc   = to ? TO : waits + 1;
        late    = !wr && !to;
        rsp_cyc = 2 + n_acc + (late ? 1 : 0);
        exp_rd  = late ? ref_mem[addr[3:2]] : 32'h0;
        chk("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        for (int c = 1; c <= rsp_cyc; c++) begin
            @(negedge clk);
            cmd_valid = hold;
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            exp_psel  = (c <= 1 + n_acc);
            exp_pen   = (c >= 2) && (c <= 1 + n_acc);
            chk("psel",      32'(PSEL),      32'(exp_psel));
            chk("penable",   32'(PENABLE),   32'(exp_pen));
            chk("rsp_valid", 32'(rsp_valid), 32'(c == rsp_cyc));
            chk("cmd_ready", 32'(cmd_ready), 32'(c == rsp_cyc));
            if (exp_psel) begin
                chk("paddr",  32'(PADDR),  32'(addr));
                chk("pwdata", PWDATA,      wr ? data : 32'h0);
                chk("pwrite", 32'(PWRITE), 32'(wr));
            end
            if (exp_pen) begin
                PREADY = ((c - 2) >= waits);
                PRDATA = $urandom;
                if (PREADY && wr) slave_mem[PADDR[3:2]] = PWDATA;
            end else if (late && c == rsp_cyc - 1) begin
                PREADY = 1'($urandom);
                PRDATA = slave_mem[addr[3:2]];
            end else begin
                PREADY = 1'($urandom);
                PRDATA = $urandom;
            end
            if (c == rsp_cyc) begin
                chk("rsp_error", 32'(rsp_error), 32'(to));
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
        end
        cmd_valid = 1'b0;
        if (wr && !to) ref_mem[addr[3:2]] = data;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            ref_mem[i]   = '0;
            slave_mem[i] = '0;
        end
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_pwrite",    32'(PWRITE),    32'd0);
        chk("rst_paddr",     32'(PADDR),     32'd0);
        chk("rst_pwdata",    PWDATA,         32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write, then late read of a value placed in DATA_IN.
        run_cmd(1'b1, 20'h4, 32'h0000_00A5, 0, 1'b0);
        @(negedge clk);
        run_cmd(1'b1, 20'h8, 32'h1234_5678, 0, 1'b0);
        @(negedge clk);
        run_cmd(1'b0, 20'h8, 32'hDEAD_BEEF, 0, 1'b0);
        @(negedge clk);

        // Wait states, boundary just below timeout, timeout, then recovery.
        run_cmd(1'b1, 20'hC, 32'hCAFE_0003, 3, 1'b0);
        run_cmd(1'b1, 20'h0, 32'h0000_0F0F, 15, 1'b0);
        run_cmd(1'b1, 20'h4, 32'hBAD0_BAD0, 16, 1'b0);
        run_cmd(1'b0, 20'h4, 32'h0, 100, 1'b0);
        run_cmd(1'b0, 20'h4, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 20'h0, 32'h0, 2, 1'b0);

        // Back-to-back writes with cmd_valid held, then read all back.
        run_cmd(1'b1, 20'h0, 32'h1111_0000, 0, 1'b1);
        run_cmd(1'b1, 20'h4, 32'h2222_0004, 0, 1'b1);
        run_cmd(1'b1, 20'h8, 32'h3333_0008, 0, 1'b1);
        run_cmd(1'b1, 20'hC, 32'h4444_000C, 0, 1'b1);
        for (int i = 0; i < 4; i++) run_cmd(1'b0, AW'(i * 4), 32'h0, 0, 1'b0);

        // Randomized commands against the reference memory.
        for (int n = 0; n < 40; n++) begin
            int gap;
            int w;
            gap = int'($urandom_range(0, 2));
            w   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                              : int'($urandom_range(0, 4));
            repeat (gap) @(negedge clk);
            run_cmd(1'($urandom), AW'($urandom), $urandom, w, 1'($urandom));
        end
        @(negedge clk);

        // Reset during the access phase of a read.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 20'hC;
        PREADY    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge clk);
        chk("abort_in_access_psel",    32'(PSEL),    32'd1);
        chk("abort_in_access_penable", 32'(PENABLE), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_psel",      32'(PSEL),      32'd0);
        chk("abort_penable",   32'(PENABLE),   32'd0);
        chk("abort_paddr",     32'(PADDR),     32'd0);
        chk("abort_pwrite",    32'(PWRITE),    32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata,      32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        run_cmd(1'b0, 20'hC, 32'h0, 1, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
